// File: rtl/playback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : playback_pkg
// Description : Shared definitions for the flash-audio playback sequencer:
//               FSM state encodings, ASCII keyboard command codes, default
//               sample-rate divisor settings and the command decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package playback_pkg;

   // Default rate settings (50 MHz system clock, 22 kHz nominal sample rate)
   localparam int DFLT_DIV_W       = 16;
   localparam int DFLT_DIV_DEFAULT = 2273;
   localparam int DFLT_DIV_STEP    = 64;
   localparam int DFLT_DIV_MIN     = 512;
   localparam int DFLT_DIV_MAX     = 16383;

   // Sequencer states
   localparam logic [1:0] ST_PAUSED    = 2'd0;
   localparam logic [1:0] ST_WAIT_TICK = 2'd1;
   localparam logic [1:0] ST_REQ       = 2'd2;
   localparam logic [1:0] ST_RESTART   = 2'd3;

   // Upper-case ASCII command keys
   localparam logic [7:0] KEY_PLAY    = 8'h45;  // 'E'
   localparam logic [7:0] KEY_PAUSE   = 8'h44;  // 'D'
   localparam logic [7:0] KEY_FWD     = 8'h46;  // 'F'
   localparam logic [7:0] KEY_BWD     = 8'h42;  // 'B'
   localparam logic [7:0] KEY_RESTART = 8'h52;  // 'R'

   // ASCII upper/lower case differ only in this bit
   localparam logic [7:0] CASE_BIT = 8'h20;

   typedef struct packed {
      logic play;
      logic pause;
      logic fwd;
      logic bwd;
      logic restart;
   } cmd_t;

   // One-hot command decode; unknown codes decode to all zeros.
   function automatic cmd_t decode_cmd(input logic valid, input logic [7:0] code);
      logic [7:0] folded;
      cmd_t       c;
      folded    = code & ~CASE_BIT;
      c.play    = valid && (folded == KEY_PLAY);
      c.pause   = valid && (folded == KEY_PAUSE);
      c.fwd     = valid && (folded == KEY_FWD);
      c.bwd     = valid && (folded == KEY_BWD);
      c.restart = valid && (folded == KEY_RESTART);
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/playback_ctrl_rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : rate_divider
// Description : Programmable sample-rate tick generator. Holds the divisor
//               register with saturating speed up/down/reset and a tick
//               counter that fires once every `divisor` enabled cycles.
// Ports       : clk, reset_all (async, active-low)
//               run       - counter advances when high, holds otherwise
//               clear     - synchronous counter clear
//               spd_up / spd_down / spd_reset - one-cycle divisor pulses
//               divisor   - current divisor
//               tick      - one-cycle sample-rate tick
// Revision    : 1.0 - initial release
// ============================================================================
module rate_divider
   import playback_pkg::*;
#(
   parameter int DIV_W       = DFLT_DIV_W,
   parameter int DIV_DEFAULT = DFLT_DIV_DEFAULT,
   parameter int DIV_STEP    = DFLT_DIV_STEP,
   parameter int DIV_MIN     = DFLT_DIV_MIN,
   parameter int DIV_MAX     = DFLT_DIV_MAX
) (
   input  logic             clk,
   input  logic             reset_all,
   input  logic             run,
   input  logic             clear,
   input  logic             spd_up,
   input  logic             spd_down,
   input  logic             spd_reset,
   output logic [DIV_W-1:0] divisor,
   output logic             tick
);

   localparam logic [DIV_W:0]   STEP_W = (DIV_W+1)'(DIV_STEP);
   localparam logic [DIV_W:0]   MIN_W  = (DIV_W+1)'(DIV_MIN);
   localparam logic [DIV_W:0]   MAX_W  = (DIV_W+1)'(DIV_MAX);
   localparam logic [DIV_W:0]   ONE_W  = (DIV_W+1)'(1);
   localparam logic [DIV_W-1:0] DEF_N  = DIV_W'(DIV_DEFAULT);

   logic [DIV_W-1:0] count;
   logic [DIV_W:0]   count_inc;
   logic [DIV_W:0]   dec_wide;
   logic [DIV_W:0]   inc_wide;
   logic [DIV_W-1:0] dec_sat;
   logic [DIV_W-1:0] inc_sat;

   // One extra bit so a borrow or carry is visible before saturation.
   assign dec_wide  = {1'b0, divisor} - STEP_W;
   assign inc_wide  = {1'b0, divisor} + STEP_W;
   assign dec_sat   = (dec_wide[DIV_W] || (dec_wide < MIN_W)) ? MIN_W[DIV_W-1:0]
                                                              : dec_wide[DIV_W-1:0];
   assign inc_sat   = (inc_wide > MAX_W) ? MAX_W[DIV_W-1:0] : inc_wide[DIV_W-1:0];

   // count >= divisor-1 written as count+1 >= divisor to avoid underflow;
   // the >= also catches a divisor that shrank below the running count.
   assign count_inc = {1'b0, count} + ONE_W;
   assign tick      = run && (count_inc >= {1'b0, divisor});

   always_ff @(posedge clk or negedge reset_all) begin
      if (!reset_all) begin
         divisor <= DEF_N;
      end else if (spd_reset) begin
         divisor <= DEF_N;
      end else if (spd_up) begin
         divisor <= dec_sat;
      end else if (spd_down) begin
         divisor <= inc_sat;
      end
   end

   always_ff @(posedge clk or negedge reset_all) begin
      if (!reset_all) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else if (run) begin
         count <= count_inc[DIV_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : playback_ctrl
// Description : Flash-audio playback sequencer. Decodes keyboard commands,
//               runs the sample-rate tick and issues one sample request per
//               tick over a req/ack handshake to the address/audio datapath.
// Ports       : clk, reset_all (async, active-low)
//               cmd_valid, cmd_code           - keyboard command strobe/code
//               spd_up, spd_down, spd_reset   - divisor control pulses
//               sample_ack / sample_req       - datapath handshake
//               read_direction                - 1 forward, 0 backward
//               restart_read                  - one-cycle address reload
//               playing, divisor, tick_overrun - status
// Revision    : 1.0 - initial release
// ============================================================================
module playback_ctrl
   import playback_pkg::*;
#(
   parameter int DIV_W       = DFLT_DIV_W,
   parameter int DIV_DEFAULT = DFLT_DIV_DEFAULT,
   parameter int DIV_STEP    = DFLT_DIV_STEP,
   parameter int DIV_MIN     = DFLT_DIV_MIN,
   parameter int DIV_MAX     = DFLT_DIV_MAX
) (
   input  logic             clk,
   input  logic             reset_all,
   input  logic             cmd_valid,
   input  logic [7:0]       cmd_code,
   input  logic             spd_up,
   input  logic             spd_down,
   input  logic             spd_reset,
   input  logic             sample_ack,
   output logic             sample_req,
   output logic             read_direction,
   output logic             restart_read,
   output logic             playing,
   output logic [DIV_W-1:0] divisor,
   output logic             tick_overrun
);

   logic [1:0] state;
   logic [1:0] state_next;
   logic       playing_next;
   logic       dir_next;
   logic       pend_dir_valid;
   logic       pend_dir_valid_next;
   logic       pend_dir;
   logic       pend_dir_next;
   logic       pend_restart;
   logic       pend_restart_next;
   logic       overrun_next;
   logic       run;
   logic       tick;
   logic       req_busy;
   cmd_t       cmd;

   assign cmd = decode_cmd(cmd_valid, cmd_code);

   // Request still outstanding this cycle: commands that would disturb the
   // datapath mid-fetch are parked until the ack.
   assign req_busy = (state == ST_REQ) && !sample_ack;

   assign run = playing && (state != ST_RESTART);

   rate_divider #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT),
      .DIV_STEP    (DIV_STEP),
      .DIV_MIN     (DIV_MIN),
      .DIV_MAX     (DIV_MAX)
   ) u_rate_divider (
      .clk       (clk),
      .reset_all (reset_all),
      .run       (run),
      .clear     (state == ST_RESTART),
      .spd_up    (spd_up),
      .spd_down  (spd_down),
      .spd_reset (spd_reset),
      .divisor   (divisor),
      .tick      (tick)
   );

   // Play mode is independent of the handshake: pause during REQ drops it
   // immediately while the request is allowed to finish.
   always_comb begin
      playing_next = playing;
      if (cmd.play) begin
         playing_next = 1'b1;
      end else if (cmd.pause) begin
         playing_next = 1'b0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_PAUSED: begin
            if (cmd.restart) begin
               state_next = ST_RESTART;
            end else if (cmd.play) begin
               state_next = ST_WAIT_TICK;
            end
         end
         ST_WAIT_TICK: begin
            if (cmd.restart) begin
               state_next = ST_RESTART;
            end else if (cmd.pause) begin
               state_next = ST_PAUSED;
            end else if (tick) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sample_ack) begin
               if (pend_restart || cmd.restart) begin
                  state_next = ST_RESTART;
               end else if (playing_next) begin
                  state_next = ST_WAIT_TICK;
               end else begin
                  state_next = ST_PAUSED;
               end
            end
         end
         default: begin
            state_next = playing_next ? ST_WAIT_TICK : ST_PAUSED;
         end
      endcase
   end

   // Direction: applied next cycle, or parked while a request is pending and
   // released on the ack cycle. A fresh command on the ack cycle wins.
   always_comb begin
      dir_next            = read_direction;
      pend_dir_valid_next = pend_dir_valid;
      pend_dir_next       = pend_dir;
      if (req_busy) begin
         if (cmd.fwd || cmd.bwd) begin
            pend_dir_valid_next = 1'b1;
            pend_dir_next       = cmd.fwd;
         end
      end else begin
         if (cmd.fwd || cmd.bwd) begin
            dir_next = cmd.fwd;
         end else if (pend_dir_valid) begin
            dir_next = pend_dir;
         end
         pend_dir_valid_next = 1'b0;
      end
   end

   assign pend_restart_next = req_busy ? (pend_restart || cmd.restart) : 1'b0;

   // Overrun clears on entry to RESTART; a tick dropped in REQ sets it.
   always_comb begin
      overrun_next = tick_overrun;
      if (state_next == ST_RESTART) begin
         overrun_next = 1'b0;
      end else if ((state == ST_REQ) && tick) begin
         overrun_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_all) begin
      if (!reset_all) begin
         state          <= ST_PAUSED;
         playing        <= 1'b0;
         read_direction <= 1'b1;
         pend_dir_valid <= 1'b0;
         pend_dir       <= 1'b1;
         pend_restart   <= 1'b0;
         tick_overrun   <= 1'b0;
      end else begin
         state          <= state_next;
         playing        <= playing_next;
         read_direction <= dir_next;
         pend_dir_valid <= pend_dir_valid_next;
         pend_dir       <= pend_dir_next;
         pend_restart   <= pend_restart_next;
         tick_overrun   <= overrun_next;
      end
   end

   // Decoded straight from the state register so reset removes them at once.
   assign sample_req   = (state == ST_REQ);
   assign restart_read = (state == ST_RESTART);

endmodule
`default_nettype wire

// File: tb/tb_playback_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_playback_ctrl
// Description : Directed self-checking bench for playback_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playback_ctrl;

   logic        clk = 1'b0;
   logic        reset_all = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_code = 8'h00;
   logic        spd_up = 1'b0;
   logic        spd_down = 1'b0;
   logic        spd_reset = 1'b0;
   logic        sample_ack = 1'b0;
   logic        sample_req;
   logic        read_direction;
   logic        restart_read;
   logic        playing;
   logic [15:0] divisor;
   logic        tick_overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];

   playback_ctrl dut (
      .clk            (clk),
      .reset_all      (reset_all),
      .cmd_valid      (cmd_valid),
      .cmd_code       (cmd_code),
      .spd_up         (spd_up),
      .spd_down       (spd_down),
      .spd_reset      (spd_reset),
      .sample_ack     (sample_ack),
      .sample_req     (sample_req),
      .read_direction (read_direction),
      .restart_read   (restart_read),
      .playing        (playing),
      .divisor        (divisor),
      .tick_overrun   (tick_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %0d expected <empty scoreboard>", tag, obs);
      end else begin
         chk(tag, obs, exp_q.pop_front());
      end
   endtask

   // All tasks start and end at a falling edge.
   task automatic send_cmd(input logic [7:0] code);
      cmd_valid = 1'b1;
      cmd_code  = code;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_req(input int limit, output int at);
      int n;
      n  = 0;
      at = -1;
      while (!sample_req && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (sample_req) at = cyc;
      else chk("req_timeout", 32'(sample_req), 32'd1);
   endtask

   task automatic ack_after(input int d);
      repeat (d) @(negedge clk);
      sample_ack = 1'b1;
      chk("req_held_until_ack", 32'(sample_req), 32'd1);
      @(negedge clk);
      sample_ack = 1'b0;
      chk("req_drop_after_ack", 32'(sample_req), 32'd0);
   endtask

   task automatic pulse(input int which);
      spd_up    = (which == 0 || which == 3 || which == 4);
      spd_down  = (which == 1 || which == 4);
      spd_reset = (which == 2 || which == 3);
      @(negedge clk);
      spd_up    = 1'b0;
      spd_down  = 1'b0;
      spd_reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int c;
      int p;
      int r0;
      int r1;
      int r2;
      int rst_cyc;
      logic seen;

      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      reset_all = 1'b1;
      @(negedge clk);
      chk("reset_sample_req", 32'(sample_req), 32'd0);
      chk("reset_read_direction", 32'(read_direction), 32'd1);
      chk("reset_restart_read", 32'(restart_read), 32'd0);
      chk("reset_playing", 32'(playing), 32'd0);
      chk("reset_divisor", 32'(divisor), 32'd2273);
      chk("reset_tick_overrun", 32'(tick_overrun), 32'd0);

      // ---------------- unknown code ----------------
      send_cmd(8'h41);
      chk("unknown_playing", 32'(playing), 32'd0);
      chk("unknown_read_direction", 32'(read_direction), 32'd1);
      chk("unknown_restart_read", 32'(restart_read), 32'd0);
      repeat (3) @(negedge clk);
      chk("unknown_no_req", 32'(sample_req), 32'd0);

      // ---------------- speed control ----------------
      m = 2273;
      for (int i = 0; i < 40; i++) begin
         m = (m - 64 < 512) ? 512 : m - 64;
         exp_q.push_back(32'(m));
         pulse(0);
         sb_check("spd_up_step", 32'(divisor));
      end
      chk("spd_up_saturated", 32'(divisor), 32'd512);
      pulse(2);
      chk("spd_reset", 32'(divisor), 32'd2273);
      pulse(0);
      chk("spd_up_once", 32'(divisor), 32'd2209);
      pulse(3);
      chk("spd_reset_over_up", 32'(divisor), 32'd2273);
      pulse(4);
      chk("spd_up_over_down", 32'(divisor), 32'd2209);
      pulse(2);
      m = 2273;
      for (int i = 0; i < 230; i++) begin
         m = (m + 64 > 16383) ? 16383 : m + 64;
         exp_q.push_back(32'(m));
         pulse(1);
         sb_check("spd_down_step", 32'(divisor));
      end
      chk("spd_down_saturated", 32'(divisor), 32'd16383);
      pulse(2);
      chk("spd_reset_from_max", 32'(divisor), 32'd2273);

      // ---------------- play, period check ----------------
      p = cyc;
      send_cmd(8'h45);
      chk("play_playing", 32'(playing), 32'd1);
      chk("play_direction", 32'(read_direction), 32'd1);
      exp_q.push_back(32'd2274);
      exp_q.push_back(32'd2273);
      exp_q.push_back(32'd2273);
      wait_req(3000, r0);
      sb_check("first_req_latency", 32'(r0 - p));
      ack_after(2);
      wait_req(3000, r1);
      sb_check("req_period_1", 32'(r1 - r0));
      ack_after(2);
      wait_req(3000, r2);
      sb_check("req_period_2", 32'(r2 - r1));
      ack_after(2);
      chk("play_no_overrun", 32'(tick_overrun), 32'd0);
      chk("play_direction_after", 32'(read_direction), 32'd1);

      // ---------------- B and R while request pending ----------------
      wait_req(3000, c);
      cmd_valid = 1'b1;
      cmd_code  = 8'h42;
      @(negedge clk);
      chk("pend_dir_not_applied", 32'(read_direction), 32'd1);
      cmd_code  = 8'h52;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pend_restart_not_applied", 32'(restart_read), 32'd0);
      repeat (8) @(negedge clk);
      chk("pend_dir_held", 32'(read_direction), 32'd1);
      chk("pend_req_held", 32'(sample_req), 32'd1);
      sample_ack = 1'b1;
      @(negedge clk);
      sample_ack = 1'b0;
      rst_cyc = cyc;
      chk("pend_req_dropped", 32'(sample_req), 32'd0);
      chk("pend_dir_applied", 32'(read_direction), 32'd0);
      chk("pend_restart_pulse", 32'(restart_read), 32'd1);
      @(negedge clk);
      chk("restart_one_cycle", 32'(restart_read), 32'd0);
      exp_q.push_back(32'd2274);
      wait_req(3000, r0);
      sb_check("restart_to_req", 32'(r0 - rst_cyc));
      ack_after(2);
      send_cmd(8'h66);
      chk("fwd_lowercase", 32'(read_direction), 32'd1);

      // ---------------- pause during request, resume ----------------
      wait_req(3000, c);
      send_cmd(8'h44);
      chk("pause_playing_drop", 32'(playing), 32'd0);
      chk("pause_req_held", 32'(sample_req), 32'd1);
      ack_after(3);
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sample_req) seen = 1'b1;
      end
      chk("paused_no_req", 32'(seen), 32'd0);
      p = cyc;
      exp_q.push_back(32'd2273);
      send_cmd(8'h65);
      chk("resume_playing", 32'(playing), 32'd1);
      wait_req(3000, r0);
      sb_check("resume_latency", 32'(r0 - p));
      ack_after(2);

      // ---------------- overrun ----------------
      wait_req(3000, c);
      repeat (100) @(negedge clk);
      chk("overrun_early", 32'(tick_overrun), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 2900; i++) begin
         @(negedge clk);
         if (!sample_req) seen = 1'b1;
      end
      chk("overrun_set", 32'(tick_overrun), 32'd1);
      chk("overrun_single_req", 32'(seen), 32'd0);
      ack_after(0);
      chk("overrun_sticky", 32'(tick_overrun), 32'd1);
      send_cmd(8'h52);
      chk("overrun_restart_pulse", 32'(restart_read), 32'd1);
      chk("overrun_cleared", 32'(tick_overrun), 32'd0);
      @(negedge clk);
      send_cmd(8'h62);
      chk("bwd_lowercase", 32'(read_direction), 32'd0);
      pulse(1);
      chk("spd_down_while_playing", 32'(divisor), 32'd2337);

      // ---------------- asynchronous reset mid-request ----------------
      wait_req(3000, c);
      #1 reset_all = 1'b0;
      #1;
      chk("areset_sample_req", 32'(sample_req), 32'd0);
      chk("areset_playing", 32'(playing), 32'd0);
      chk("areset_read_direction", 32'(read_direction), 32'd1);
      chk("areset_restart_read", 32'(restart_read), 32'd0);
      chk("areset_divisor", 32'(divisor), 32'd2273);
      chk("areset_tick_overrun", 32'(tick_overrun), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_all = 1'b1;
      @(negedge clk);
      send_cmd(8'h41);
      chk("post_reset_unknown_playing", 32'(playing), 32'd0);
      repeat (5) @(negedge clk);
      chk("post_reset_no_req", 32'(sample_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
